// File: rtl/banked_mem_responder.sv
// banked_mem_responder
// Four-bank, word-interleaved memory responder for the cache memory port.
// Bank = addr[2:1], row = addr[ADDR_W-1:3]. An accepted request holds its
// bank for three cycles. Read data comes back two cycles after acceptance.
//
// Optional feature macro: BANKED_MEM_UNALIGNED_ERR_EN
//   defined     : a request with addr[0]==1 is an error (dropped, err pulse)
//   not defined : addr[0] is ignored, so the request uses its aligned word
//
// Handshake: a request (rd|wr) that is not an error is accepted at the rising
// edge where stall==0. While stall==1 the requester holds rd/wr/addr/data_in
// stable. Error requests never stall. They are dropped at the next edge and
// reported on err one cycle later.
module banked_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [3:0]        busy,
  output logic              stall,
  output logic              err
);

  localparam int ROWS  = WORDS / 4;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [DATA_W-1:0] mem [0:3][0:ROWS-1];
  logic [DATA_W-1:0] rd_reg [0:3];
  logic [1:0]        cnt [0:3];
  logic [3:0]        op;

  logic [1:0]        bank;
  logic [ROW_W-1:0]  row;
  logic              req;
  logic              unaligned;
  logic              bad;
  logic              accept;
  logic              ret_hit;
  logic [1:0]        ret_bank;
  logic              unused_addr_bits;

  assign bank = addr[2:1];
  assign row  = addr[3 +: ROW_W];

  // Upper row bits beyond the array depth, and addr[0] in the default
  // build, carry no meaning here.
  assign unused_addr_bits = ^addr;

`ifdef BANKED_MEM_UNALIGNED_ERR_EN
  assign unaligned = addr[0];
`else
  assign unaligned = 1'b0;
`endif

  // Request classification: an error beats a stall, and a stall beats an accept.
  assign req    = rd | wr;
  assign bad    = req & ((rd & wr) | unaligned);
  assign stall  = req & ~bad & busy[bank];
  assign accept = req & ~bad & ~busy[bank];

  // A bank stays busy while its down-counter is non-zero.
  always_comb begin
    busy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      busy[b] = (cnt[b] != 2'd0);
    end
  end

  // Per-bank occupancy counter, op flag and read capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        cnt[b]    <= 2'd0;
        rd_reg[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank == 2'(b))) begin
          cnt[b] <= 2'd3;
          op[b]  <= rd;
          if (rd) begin
            rd_reg[b] <= mem[b][row];
          end
        end else if (cnt[b] != 2'd0) begin
          cnt[b] <= cnt[b] - 2'd1;
        end
      end
    end
  end

  // Storage array. It has no reset, so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[bank][row] <= data_in;
    end
  end

  // Find the read bank whose counter reaches 1 at the next edge. At most one
  // bank can match, because only one request is accepted per cycle.
  always_comb begin
    ret_hit  = 1'b0;
    ret_bank = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (op[b] && (cnt[b] == 2'd2)) begin
        ret_hit  = 1'b1;
        ret_bank = 2'(b);
      end
    end
  end

  // Return path. rd_valid is high for the single cycle in which cnt==1.
  // data_out keeps the last returned word until the next return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= ret_hit;
      if (ret_hit) begin
        data_out <= rd_reg[ret_bank];
      end
    end
  end

  // Error pulse, one cycle per dropped request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= bad;
    end
  end

endmodule

// File: tb/tb_banked_mem_responder.sv
// tb_banked_mem_responder
// Directed test of banked_mem_responder. Driver tasks issue requests and push
// expected read data and error pulses, with their cycles, into queues. A
// monitor on the falling edge pops the queues and compares whenever the DUT
// raises rd_valid or err.
module tb_banked_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd_valid;
  logic [3:0]  busy;
  logic        stall;
  logic        err;

  int          cyc;
  int          checks;
  int          errors;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          err_q[$];
  logic [15:0] model_mem [0:2047];

  logic [15:0] mon_data;
  int          mon_cyc;
  int          s;
  int          bcount;
  int          vcount;

  banked_mem_responder #(
    .ADDR_W(16),
    .DATA_W(16),
    .WORDS (2048)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .busy    (busy),
    .stall   (stall),
    .err     (err)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request and hold it until it is accepted, which is the first
  // edge with stall low. Then record what the response should be.
  task automatic issue(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input bit track, output int stalls);
    bit done;
    bit is_err;
    stalls = 0;
    done   = 1'b0;
    is_err = r & w;
`ifdef BANKED_MEM_UNALIGNED_ERR_EN
    is_err = is_err | ((r | w) & a[0]);
`endif
    rd      = r;
    wr      = w;
    addr    = a;
    data_in = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        stalls = stalls + 1;
      end else begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout addr=%0h stall cycles=%0d required below 20", a, stalls);
    end else if (is_err) begin
      err_q.push_back(cyc);
    end else if (w) begin
      model_mem[a[11:1]] = d;
    end else if (track) begin
      exp_q.push_back(model_mem[a[11:1]]);
      exp_cyc_q.push_back(cyc + 2);
    end
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_rd_valid data_out=%0h at cycle %0d, required no return", data_out, cyc);
        end else begin
          mon_data = exp_q.pop_front();
          mon_cyc  = exp_cyc_q.pop_front();
          check("rd_data", data_out, mon_data);
          check("rd_latency_cycle", cyc, mon_cyc);
        end
      end
      if (err) begin
        if (err_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_err at cycle %0d, required no pulse", cyc);
        end else begin
          mon_cyc = err_q.pop_front();
          check("err_cycle", cyc, mon_cyc);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;
    idle(2);
    check("reset_busy", busy, 4'b0000);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_data_out", data_out, 16'h0000);
    check("reset_err", err, 1'b0);
    check("reset_stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Preload one word in each bank, back to back, plus a word at 0x0020.
    issue(1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, s);
    issue(1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, s);
    issue(1'b0, 1'b1, 16'h0004, 16'h3333, 1'b0, s);
    issue(1'b0, 1'b1, 16'h0006, 16'h4444, 1'b0, s);
    issue(1'b0, 1'b1, 16'h0020, 16'h5A5A, 1'b0, s);
    idle(5);

    // Write 0xBEEF, read it back later, and measure bank 0 occupancy.
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, s);
    idle(4);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, s);
    check("t1_read_stall", s, 0);
    bcount = 0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy[0]) bcount = bcount + 1;
      if (rd_valid) vcount = vcount + 1;
    end
    check("t1_busy0_cycles", bcount, 3);
    check("t1_rd_valid_cycles", vcount, 1);
    idle(3);

    // Reads to all four banks on consecutive cycles
    issue(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, s);
    check("t2_stall_b0", s, 0);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, s);
    check("t2_stall_b1", s, 0);
    issue(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, s);
    check("t2_stall_b2", s, 0);
    issue(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1, s);
    check("t2_stall_b3", s, 0);
    check("t2_busy_after_last", busy, 4'b1110);
    idle(6);

    // Same-bank conflict: the read stalls for three cycles.
    issue(1'b0, 1'b1, 16'h0008, 16'h7777, 1'b0, s);
    check("t3_write_stall", s, 0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, s);
    check("t3_read_stall_cycles", s, 3);
    idle(6);

    // rd and wr together: the request is dropped and err pulses.
    issue(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b0, s);
    check("t4_rdwr_stall", s, 0);
    check("t4_rdwr_busy", busy, 4'b0000);
    idle(3);
    // Unaligned read: an error with the macro, otherwise it reads 0x0020.
    issue(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, s);
    check("t4_unaligned_stall", s, 0);
    idle(6);

    // Reset while a read is in flight
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, s);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 4'b0000);
    check("t5_rst_rd_valid", rd_valid, 1'b0);
    check("t5_rst_data_out", data_out, 16'h0000);
    check("t5_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, s);
    issue(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, s);
    idle(8);

    check("read_queue_drained", exp_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
